eco32f_cache_refill: RTL and testbench

ECO32F_CACHE_REFILL -- requirements
Module: eco32f_cache_refill

---
 rtl/eco32f_cache_refill.sv | 134 +++++++++++++
 tb/tb_eco32f_cache_refill.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_cache_refill.sv
// Cache line refill and whole-cache flush engine for the eco32f core.
// It fetches a 32-byte line over a Wishbone incrementing burst, or invalidates all 128 tag entries.
module eco32f_cache_refill (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] req_addr,
  input  logic        flush_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cache_write_addr,
  output logic [31:0] cache_write_data,
  output logic        cache_write_en,
  output logic        cache_invalidate,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  beat_reg, beat_next;
  logic [6:0]  idx_reg, idx_next;
  logic [31:0] adr_reg, adr_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      beat_reg  <= 3'd0;
      idx_reg   <= 7'd0;
      adr_reg   <= 32'd0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      idx_reg   <= idx_next;
      adr_reg   <= adr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    idx_next   = idx_reg;
    adr_next   = adr_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
          idx_next   = 7'd0;
        end else if (req) begin
          state_next = REFILL;
          adr_next   = {req_addr[31:5], 5'b0};
          beat_next  = 3'd0;
        end
      end
      REFILL: begin
        // A bus error outranks a simultaneous ack: the beat is discarded.
        if (wbm_err_i) begin
          state_next = IDLE;
          beat_next  = 3'd0;
          err_next   = 1'b1;
        end else if (wbm_ack_i) begin
          if (beat_reg == 3'd7) begin
            state_next = IDLE;
            beat_next  = 3'd0;
            done_next  = 1'b1;
          end else begin
            beat_next = beat_reg + 3'd1;
            adr_next  = adr_reg + 32'd4;
          end
        end
      end
      FLUSH: begin
        idx_next = idx_reg + 7'd1;
        if (idx_reg == 7'd127) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic refill_write;
  assign refill_write = (state_reg == REFILL) && wbm_ack_i && !wbm_err_i;

  always_comb begin
    cache_write_en   = 1'b0;
    cache_invalidate = 1'b0;
    cache_write_addr = 32'd0;
    cache_write_data = 32'd0;
    if (refill_write) begin
      cache_write_en   = 1'b1;
      // The tag only turns valid with the last word, so a partial line never hits.
      cache_invalidate = (beat_reg != 3'd7);
      cache_write_addr = adr_reg;
      cache_write_data = wbm_dat_i;
    end else if (state_reg == FLUSH) begin
      cache_write_en   = 1'b1;
      cache_invalidate = 1'b1;
      cache_write_addr = {20'b0, idx_reg, 5'b0};
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_cyc_o = (state_reg == REFILL);
  assign wbm_stb_o = (state_reg == REFILL);
  assign wbm_cti_o = (state_reg != REFILL) ? 3'b000 :
                     (beat_reg == 3'd7)    ? 3'b111 : 3'b010;
  assign wbm_bte_o = 2'b00;

endmodule

// File: tb/tb_eco32f_cache_refill.sv
// Directed bench for eco32f_cache_refill: refills with and without wait states,
// bus error abort, flush priority, and asynchronous reset in mid-burst.
module tb_eco32f_cache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] req_addr;
  logic        flush_req;
  logic        busy, done, err;
  logic [31:0] cache_write_addr, cache_write_data;
  logic        cache_write_en, cache_invalidate;
  logic [31:0] wbm_adr_o;
  logic        wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  int vectors = 0;
  int miscompares = 0;

  eco32f_cache_refill dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .flush_req(flush_req),
    .busy(busy), .done(done), .err(err),
    .cache_write_addr(cache_write_addr), .cache_write_data(cache_write_data),
    .cache_write_en(cache_write_en), .cache_invalidate(cache_invalidate),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One refill beat entered at a negedge: optional wait cycles, then the acked beat.
  task automatic beat(input logic [31:0] base, input int b, input int waits);
    for (int w = 0; w < waits; w++) begin
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'd0;
      #1;
      chk("wait_cyc", {31'd0, wbm_cyc_o}, 32'd1);
      chk("wait_we", {31'd0, cache_write_en}, 32'd0);
      chk("wait_adr", wbm_adr_o, base + 32'(4 * b));
      @(negedge clk);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hC0DE_0000 + 32'(b);
    #1;
    chk("beat_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    chk("beat_adr", wbm_adr_o, base + 32'(4 * b));
    chk("beat_cti", {29'd0, wbm_cti_o}, (b == 7) ? 32'd7 : 32'd2);
    chk("beat_bte", {30'd0, wbm_bte_o}, 32'd0);
    chk("beat_we", {31'd0, cache_write_en}, 32'd1);
    chk("beat_waddr", cache_write_addr, base + 32'(4 * b));
    chk("beat_wdata", cache_write_data, 32'hC0DE_0000 + 32'(b));
    chk("beat_inval", {31'd0, cache_invalidate}, (b == 7) ? 32'd0 : 32'd1);
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'd0;
  endtask

  // Checks the cycle after the final ack: done pulse, bus released, then pulse gone.
  task automatic expect_done;
    #1;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("done_cti", {29'd0, wbm_cti_o}, 32'd0);
    chk("done_err", {31'd0, err}, 32'd0);
    chk("done_we", {31'd0, cache_write_en}, 32'd0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  // Issue a request at a negedge; returns at the first REFILL negedge.
  task automatic start_refill(input logic [31:0] addr, input logic [31:0] base);
    req = 1'b1;
    req_addr = addr;
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_adr", wbm_adr_o, base);
  endtask

  initial begin
    int waits [8] = '{1, 0, 3, 2, 0, 1, 2, 3};
    rst = 1'b0; req = 1'b0; req_addr = 32'd0; flush_req = 1'b0;
    wbm_dat_i = 32'd0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_cti", {29'd0, wbm_cti_o}, 32'd0);
    chk("rst_we_inval", {30'd0, cache_write_en, cache_invalidate}, 32'd0);
    chk("rst_waddr", cache_write_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Refill 0x1234 with ack every cycle
    start_refill(32'h0000_1234, 32'h0000_1220);
    for (int b = 0; b < 8; b++) beat(32'h0000_1220, b, 0);
    expect_done();

    // Same refill with wait states
    @(negedge clk);
    start_refill(32'h0000_1234, 32'h0000_1220);
    for (int b = 0; b < 8; b++) beat(32'h0000_1220, b, waits[b]);
    expect_done();

    // Bus error on beat 3 (with ack also high), new request in the err cycle
    @(negedge clk);
    start_refill(32'h0000_ABCD, 32'h0000_ABC0);
    for (int b = 0; b < 3; b++) beat(32'h0000_ABC0, b, 0);
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    #1;
    chk("err_no_write", {31'd0, cache_write_en}, 32'd0);
    chk("err_cyc_held", {31'd0, wbm_cyc_o}, 32'd1);
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    req = 1'b1;
    req_addr = 32'h0000_0040;
    #1;
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_no_done", {31'd0, done}, 32'd0);
    chk("err_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
    chk("err_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("err_pulse_end", {31'd0, err}, 32'd0);
    chk("reaccept_busy", {31'd0, busy}, 32'd1);
    chk("reaccept_adr", wbm_adr_o, 32'h0000_0040);
    for (int b = 0; b < 8; b++) beat(32'h0000_0040, b, 0);
    expect_done();

    // Flush wins over simultaneous req; req held through the flush
    @(negedge clk);
    flush_req = 1'b1;
    req = 1'b1;
    req_addr = 32'h0000_2010;
    @(negedge clk);
    flush_req = 1'b0;
    for (int i = 0; i < 128; i++) begin
      #1;
      chk("flush_we", {31'd0, cache_write_en}, 32'd1);
      chk("flush_inval", {31'd0, cache_invalidate}, 32'd1);
      chk("flush_addr", cache_write_addr, 32'(i * 32));
      chk("flush_no_bus", {31'd0, wbm_cyc_o}, 32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd1);
      chk("flush_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("flush_done", {31'd0, done}, 32'd1);
    chk("flush_idle", {31'd0, busy}, 32'd0);
    chk("flush_end_we", {31'd0, cache_write_en}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("post_flush_busy", {31'd0, busy}, 32'd1);
    chk("post_flush_adr", wbm_adr_o, 32'h0000_2000);
    for (int b = 0; b < 8; b++) beat(32'h0000_2000, b, 0);
    expect_done();

    // Asynchronous reset during beat 5
    @(negedge clk);
    start_refill(32'h0000_3000, 32'h0000_3000);
    for (int b = 0; b < 5; b++) beat(32'h0000_3000, b, 0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("arst_we", {31'd0, cache_write_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_adr", wbm_adr_o, 32'd0);
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'd0;
    rst = 1'b1;
    #1;
    chk("arst_no_pulse", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    #1;
    chk("arst_idle", {31'd0, busy}, 32'd0);
    chk("arst_no_pulse2", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    start_refill(32'h0000_3004, 32'h0000_3000);
    for (int b = 0; b < 8; b++) beat(32'h0000_3000, b, 0);
    expect_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
